// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch controller.
// The optional branch delay slot is enabled by defining PC_FETCH_DELAY_SLOT_EN.
package pc_fetch_pkg;

    localparam int PC_W        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC   = 32'hBFC0_0000;
    localparam logic [PC_W-1:0] DEFAULT_EXC_VECTOR = 32'hBFC0_0380;
    localparam logic [PC_W-1:0] PC_ALIGN_MASK      = ~PC_W'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        WAIT,
        FULL
    } state_e;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Owns the architectural PC, issues one instruction fetch at a time and buffers one word for decode.
// Define PC_FETCH_DELAY_SLOT_EN to model the MIPS branch delay slot.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [PC_W-1:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [PC_W-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [PC_W-1:0] instr,
    output logic [PC_W-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            exc_valid,
    output logic [PC_W-1:0] epc
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic            kill_q, kill_d;
    logic [PC_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0] instr_pc_q, instr_pc_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic [PC_W-1:0] redir_pc;

`ifdef PC_FETCH_DELAY_SLOT_EN
    logic            pend_q, pend_d;
    logic [PC_W-1:0] target_q, target_d;
    // slot_q marks the delay-slot instruction from its grant until decode accepts it.
    logic            slot_q, slot_d;
`endif

    assign redir_pc = align_pc(redirect_pc);

    always_comb begin
        // NOTE: every *_d gets its hold value first so no path through this block can infer a latch.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        kill_d     = kill_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        epc_d      = epc_q;
`ifdef PC_FETCH_DELAY_SLOT_EN
        pend_d     = pend_q;
        target_d   = target_q;
        slot_d     = slot_q;
`endif

        if (exc_valid) begin
            fetch_pc_d = EXC_VECTOR;
`ifdef PC_FETCH_DELAY_SLOT_EN
            pend_d     = 1'b0;
            slot_d     = 1'b0;
`endif
            unique case (state_q)
                FULL: begin
                    epc_d   = instr_pc_q;
                    addr_d  = EXC_VECTOR;
                    state_d = REQ;
                end
                WAIT: begin
                    epc_d = addr_q;
                    // A response arriving with the exception has drained: restart directly.
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        addr_d  = EXC_VECTOR;
                        state_d = REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end
                REQ: begin
                    epc_d   = addr_q;
                    kill_d  = 1'b1;
                    state_d = imem_gnt ? WAIT : REQ;
                end
                default: begin
                    epc_d   = addr_q;
                    addr_d  = EXC_VECTOR;
                    state_d = REQ;
                end
            endcase
        end else begin
            unique case (state_q)
                BOOT: state_d = REQ;
                REQ: begin
                    if (imem_gnt) begin
                        state_d = WAIT;
                        if (kill_q) begin
                            fetch_pc_d = fetch_pc_q;
`ifdef PC_FETCH_DELAY_SLOT_EN
                        end else if (pend_q) begin
                            fetch_pc_d = target_q;
                            pend_d     = 1'b0;
                            slot_d     = 1'b1;
`endif
                        end else begin
                            fetch_pc_d = addr_q + PC_W'(INSTR_BYTES);
                        end
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            addr_d  = fetch_pc_q;
                            state_d = REQ;
                        end else begin
                            instr_d    = imem_rdata;
                            instr_pc_d = addr_q;
                            state_d    = FULL;
                        end
                    end
                end
                FULL: begin
                    if (instr_ready) begin
                        state_d = REQ;
                        addr_d  = fetch_pc_q;
`ifdef PC_FETCH_DELAY_SLOT_EN
                        slot_d  = 1'b0;
                        if (redirect_valid && !pend_q && !slot_q) begin
                            target_d = redir_pc;
                            pend_d   = 1'b1;
                        end
`else
                        if (redirect_valid) begin
                            fetch_pc_d = redir_pc;
                            addr_d     = redir_pc;
                        end
`endif
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            kill_q     <= 1'b0;
            // NOTE: the one-entry buffer is reset so decode never sees stale data after reset.
            instr_q    <= '0;
            instr_pc_q <= '0;
            epc_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            kill_q     <= kill_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            epc_q      <= epc_d;
        end
    end

`ifdef PC_FETCH_DELAY_SLOT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= 1'b0;
            target_q <= '0;
            slot_q   <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            target_q <= target_d;
            slot_q   <= slot_d;
        end
    end
`endif

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = addr_q;
    assign instr_valid = (state_q == FULL);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign epc         = epc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl against a memory that returns word(a) = a ^ 1.
// Expectations follow the build: PC_FETCH_DELAY_SLOT_EN selects the delay-slot sequences.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_valid;
    logic [31:0] epc;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          gnt_delay = 0;
    int          rsp_delay = 0;
    int          req_age   = 0;
    int          rsp_cnt   = 0;
    bit          rsp_pend  = 1'b0;
    logic [31:0] rsp_addr  = '0;
    logic [31:0] issued_q[$];

    pc_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_valid      (exc_valid),
        .epc            (epc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end

    // Memory responder: grants after gnt_delay request cycles, answers rsp_delay cycles after the first legal one.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (!rst_n) begin
                rsp_pend = 1'b0;
                req_age  = 0;
            end else begin
                if (rsp_pend) begin
                    if (rsp_cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = rsp_addr ^ 32'h1;
                        rsp_pend    = 1'b0;
                    end else begin
                        rsp_cnt--;
                    end
                end
                if (imem_req) begin
                    if (req_age >= gnt_delay) begin
                        imem_gnt = 1'b1;
                        rsp_pend = 1'b1;
                        rsp_cnt  = rsp_delay;
                        rsp_addr = imem_addr;
                        issued_q.push_back(imem_addr);
                        req_age  = 0;
                    end else begin
                        req_age++;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        exc_valid      = 1'b0;
        gnt_delay      = 0;
        rsp_delay      = 0;
        repeat (2) @(negedge clk);
        issued_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_instr(input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < max_cyc);
        check("instr_arrives", 32'(instr_valid), 32'd1);
    endtask

    // Hold the handshake for exactly one cycle with the given redirect/exception inputs.
    task automatic accept(input logic rv, input logic [31:0] rpc, input logic ex);
        instr_ready    = 1'b1;
        redirect_valid = rv;
        redirect_pc    = rpc;
        exc_valid      = ex;
        @(negedge clk);
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        exc_valid      = 1'b0;
    endtask

    // Leaves the controller requesting pc; with a delay slot the slot instruction is accepted first.
    task automatic goto_pc(input logic [31:0] pc);
        int n;
        accept(1'b1, pc, 1'b0);
`ifdef PC_FETCH_DELAY_SLOT_EN
        wait_instr(40, n);
        accept(1'b0, 32'h0, 1'b0);
`else
        n = 0;
`endif
    endtask

    initial begin
        int n;
        bit saw_valid;

        rst_n          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        exc_valid      = 1'b0;

        // Reset values and streaming fetch with decode always ready.
        do_reset();
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, 32'hBFC0_0000);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_epc", epc, 32'h0);
        instr_ready = 1'b1;
        @(negedge clk);
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'hBFC0_0000);
        wait_instr(10, n);
        check("first_latency", 32'(n), 32'd2);
        check("stream0_pc", instr_pc, 32'hBFC0_0000);
        check("stream0_instr", instr, 32'hBFC0_0001);
        wait_instr(10, n);
        check("stream1_spacing", 32'(n), 32'd3);
        check("stream1_pc", instr_pc, 32'hBFC0_0004);
        wait_instr(10, n);
        check("stream2_spacing", 32'(n), 32'd3);
        check("stream2_pc", instr_pc, 32'hBFC0_0008);
        check("stream2_instr", instr, 32'hBFC0_0009);
        check("issued0", issued_q[0], 32'hBFC0_0000);
        check("issued1", issued_q[1], 32'hBFC0_0004);
        check("issued2", issued_q[2], 32'hBFC0_0008);

        // Reset mid-stream, then decode stalls for 5 cycles on the first instruction.
        do_reset();
        check("rerst_imem_req", 32'(imem_req), 32'd0);
        wait_instr(10, n);
        check("stall_first_pc", instr_pc, 32'hBFC0_0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_no_req", 32'(imem_req), 32'd0);
        end
        check("stall_valid", 32'(instr_valid), 32'd1);
        check("stall_instr", instr, 32'hBFC0_0001);
        check("stall_pc", instr_pc, 32'hBFC0_0000);
        accept(1'b0, 32'h0, 1'b0);
        check("stall_release_req", 32'(imem_req), 32'd1);
        check("stall_release_addr", imem_addr, 32'hBFC0_0004);

        // Redirect on the instruction at 0x100.
        wait_instr(10, n);
        goto_pc(32'h0000_0100);
        check("goto_100_addr", imem_addr, 32'h0000_0100);
        wait_instr(10, n);
        check("at_100_pc", instr_pc, 32'h0000_0100);
        check("at_100_instr", instr, 32'h0000_0101);
        accept(1'b1, 32'h0000_0400, 1'b0);
`ifdef PC_FETCH_DELAY_SLOT_EN
        check("slot_addr", imem_addr, 32'h0000_0104);
        wait_instr(10, n);
        check("slot_pc", instr_pc, 32'h0000_0104);
        accept(1'b1, 32'h0000_0800, 1'b0);
        check("slot_redirect_ignored", imem_addr, 32'h0000_0400);
`else
        check("redirect_addr", imem_addr, 32'h0000_0400);
`endif
        wait_instr(10, n);
        check("target_pc", instr_pc, 32'h0000_0400);

        // Exception while waiting for the 0x200 response, grant delayed 3 cycles.
        gnt_delay = 3;
        rsp_delay = 2;
        goto_pc(32'h0000_0200);
        check("exc_req_addr", imem_addr, 32'h0000_0200);
        for (int i = 0; i < 20 && imem_req; i++) @(negedge clk);
        check("exc_granted", 32'(imem_req), 32'd0);
        exc_valid = 1'b1;
        @(negedge clk);
        exc_valid = 1'b0;
        gnt_delay = 0;
        rsp_delay = 0;
        check("exc_epc", epc, 32'h0000_0200);
        saw_valid = 1'b0;
        for (int i = 0; i < 20 && !imem_req; i++) begin
            @(negedge clk);
            if (instr_valid) saw_valid = 1'b1;
        end
        check("exc_vec_req", 32'(imem_req), 32'd1);
        check("exc_vec_addr", imem_addr, 32'hBFC0_0380);
        check("exc_dropped", 32'(saw_valid), 32'd0);
        wait_instr(10, n);
        check("exc_vec_pc", instr_pc, 32'hBFC0_0380);
        check("exc_vec_instr", instr, 32'hBFC0_0381);

        // Exception and redirect in the same handshake cycle.
        accept(1'b0, 32'h0, 1'b0);
        wait_instr(10, n);
        check("pre_exc_pc", instr_pc, 32'hBFC0_0384);
        accept(1'b1, 32'h0000_0300, 1'b1);
        check("both_addr", imem_addr, 32'hBFC0_0380);
        check("both_epc", epc, 32'hBFC0_0384);
        check("both_valid_drop", 32'(instr_valid), 32'd0);
        wait_instr(10, n);
        check("both_vec_pc", instr_pc, 32'hBFC0_0380);
        accept(1'b0, 32'h0, 1'b0);
        check("both_redirect_discarded", imem_addr, 32'hBFC0_0384);

        // Unaligned redirect to the top of memory and wrap to zero.
        wait_instr(10, n);
        goto_pc(32'hFFFF_FFFF);
        check("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
        wait_instr(10, n);
        check("wrap_top_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_top_instr", instr, 32'hFFFF_FFFD);
        accept(1'b0, 32'h0, 1'b0);
        check("wrap_zero_addr", imem_addr, 32'h0000_0000);
        wait_instr(10, n);
        check("wrap_zero_pc", instr_pc, 32'h0000_0000);
        check("wrap_zero_instr", instr, 32'h0000_0001);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
